// File: rtl/uart_rx_if.sv
// Received-word stream between uart_rx and its consumer.
// The receiver drives data/valid and the error pulses; the consumer drives ready.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  frame_err;
  logic                  overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronises rx, samples each bit at its centre and
// delivers words on a valid/ready stream with frame-error and overrun pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master stream
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH + 1);
  localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic                  rx_meta_reg;
  logic                  rx_s_reg;
  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  stop_good;
  logic                  stop_bad;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;

  // Line idles high, so the synchroniser resets to 1 to avoid a fake start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = HALF_CNT;
        end
      end
      START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (!rx_s_reg) begin
          state_next   = DATA;
          cnt_next     = FULL_CNT;
          bit_idx_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          // LSB arrives first, so shift in from the top
          shift_next = DATA_WIDTH'({rx_s_reg, shift_reg} >> 1);
          cnt_next   = FULL_CNT;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = rx_s_reg ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (state_reg == STOP && cnt_reg == '0) begin
      stop_good = rx_s_reg;
      stop_bad  = !rx_s_reg;
    end
  end

  // A pending word is never overwritten; a new one only replaces it when it is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= 1'b0;
      if (stop_good) begin
        if (!valid_reg || stream.ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && stream.ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign stream.data      = data_reg;
  assign stream.valid     = valid_reg;
  assign stream.frame_err = frame_err_reg;
  assign stream.overrun   = overrun_reg;

endmodule
